decode_seq: RTL and testbench
=============================

DECODE_SEQ -- requirements
Module: decode_seq

Interface
REQ-001 Parameter NREG, default 16, is the register-list width for block transfers; legal values are 8 and 16.
REQ-002 Parameter OFFW, default $clog2(NREG)+2, is the width of the micro-op byte offset.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low; asserting it (0) clears all state immediately.
REQ-005 InstrD  input  32  instruction in Decode; Op=InstrD[27:26], Funct=InstrD[25:20], Rd=InstrD[15:12].
REQ-006 ValidD  input  1  InstrD holds a real instruction.
REQ-007 StallD  input  1  hazard stall; holds Decode state and the E register.
REQ-008 FlushD  input  1  branch redirect; aborts any block transfer in progress.
REQ-009 FlushE  input  1  loads a bubble into the E register.
REQ-010 RegSrcD  output  2  combinational register-file read select for the current Decode micro-op.
REQ-011 ImmSrcD  output  2  combinational immediate-extend select for the current Decode micro-op.
REQ-012 BusyD  output  1  sequencer needs more cycles; Fetch shall hold InstrD.
REQ-013 RegWE, MemWE, MemtoRegE, ALUSrcE, BranchE, PCSE, NoWriteE  output  1 each  registered controls.
REQ-014 ALUControlE  output  3; FlagWE  output  2  registered.
REQ-015 UopRdE  output  $clog2(NREG)  registered; UopOffE  output  OFFW  registered byte offset; UopE  output  1  registered micro-op flag.

Function
REQ-016 Single-cycle decode: Op=00 is data-processing, Op=01 is LDR/STR, Op=10 with Funct[5]=1 is branch; encodings match the current decode block.
REQ-017 ALU codes: ADD 000, SUB 001, AND 010, ORR 011, EOR 110. TST/TEQ/CMP/CMN set NoWrite=1 and RegW=0.
REQ-018 FlagW[1]=S; FlagW[0]=S AND (ADD or SUB class). Both are 0 for non-ALU instructions.
REQ-019 PCS = (Rd=15 AND RegW) OR Branch.
REQ-020 The E register latches on every clk edge unless StallD=1; latency is one cycle from Decode to E outputs.
REQ-021 FlushE=1 (not stalled), or ValidD=0, loads a bubble: all E write/branch controls 0.
REQ-022 FlushE takes priority over StallD.
REQ-023 The FSM has two states, IDLE and XFER.
REQ-024 Block transfer: Op=10, Funct[5]=0, L=Funct[0], list=InstrD[NREG-1:0], base Rn.
  - Popcount n ≥ 2: one micro-op per set bit, lowest index first.
  - Entering XFER: IDLE→XFER on the first micro-op.
  - Leaving XFER: XFER→IDLE after micro-op n.
REQ-025 Micro-op k (0-based) has Rd = index of the k-th set bit and offset 4·k (increment-after). Offset arithmetic is modulo 2^OFFW. The P, U and W bits are ignored.
REQ-026 LDM micro-op: RegW=1, MemtoReg=1, MemW=0, ALUSrc=1, ALUControl=ADD. STM micro-op: MemW=1, RegW=0. UopE=1 in both cases.
REQ-027 BusyD=1 in every Decode cycle of a block transfer except its last micro-op.
REQ-028 n=1 completes in one cycle with BusyD=0. n=0 issues one bubble with BusyD=0.
REQ-029 LDM with R15 in the list sets PCSE=1 on that micro-op only.
REQ-030 StallD=1 in XFER freezes the remaining list, k and state.
REQ-031 FlushD=1 forces the next state to IDLE and discards the remaining list; same-cycle FlushE still bubbles E.

Reset
REQ-032 While reset=0: FSM=IDLE, remaining list=0, k=0, every E output=0, BusyD=0.
REQ-033 Reset mid-transfer abandons the transfer. After release, decoding resumes on the next valid InstrD.

Configuration
REQ-034 DECODE_BLOCKXFER_EN defined: block transfers are sequenced as specified above.
REQ-035 DECODE_BLOCKXFER_EN undefined: Op=10 with Funct[5]=0 decodes as a bubble, BusyD is tied 0, UopE/UopRdE/UopOffE are tied 0, and no FSM is synthesised.

Structure
REQ-036 Package decode_pkg shall hold the ALU code constants, the Op field constants and the FSM state enum.
REQ-037 Sub-module reglist_pe (parameter NREG) shall return the lowest set-bit index and a valid flag. The remaining list clears that bit each micro-op.

Verification
REQ-038 ADDS R1,R2,R3 (0xE0921003) → next cycle: RegWE=1, ALUControlE=000, FlagWE=11, NoWriteE=0.
REQ-039 CMP R0,#5 (0xE3500005) → RegWE=0, NoWriteE=1, FlagWE=11, ALUControlE=001.
REQ-040 LDMIA R0,{R1,R4,R7} (0xE8900092) → 3 micro-ops, UopRdE=1,4,7, UopOffE=0,4,8, BusyD=1,1,0.
REQ-041 STM list 0x0003 with StallD=1 for 2 cycles after micro-op 0 → UopRdE=1 is held, then issues once; total 4 cycles.
REQ-042 LDM list 0x00FF with FlushD=1 at micro-op 3 → FSM=IDLE next cycle, BusyD=0, no further micro-ops.
REQ-043 reset=0 asserted asynchronously during micro-op 2 of an 8-register LDM → all E outputs 0 before the next clk edge.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode constants: instruction Op field, ALU codes, E-stage control bundle and
// the block-transfer sequencer state.
package decode_pkg;

  localparam logic [1:0] OpDp  = 2'b00;
  localparam logic [1:0] OpMem = 2'b01;
  localparam logic [1:0] OpBr  = 2'b10;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOrr = 3'b011;
  localparam logic [2:0] AluEor = 3'b110;

  typedef struct packed {
    logic       regw;
    logic       memw;
    logic       memtoreg;
    logic       alusrc;
    logic       branch;
    logic       pcs;
    logic       nowrite;
    logic [2:0] alu;
    logic [1:0] flagw;
  } ectl_t;

  typedef enum logic {StIdle, StXfer} state_e;

endpackage

// File: rtl/decode_seq_if.sv
// Decode-stage bus: instruction/hazard inputs and the registered E-stage controls.
interface decode_seq_if #(
  parameter int unsigned NREG = 16,
  parameter int unsigned OFFW = $clog2(NREG) + 2
);
  logic [31:0]             InstrD;
  logic                    ValidD;
  logic                    StallD;
  logic                    FlushD;
  logic                    FlushE;
  logic [1:0]              RegSrcD;
  logic [1:0]              ImmSrcD;
  logic                    BusyD;
  logic                    RegWE;
  logic                    MemWE;
  logic                    MemtoRegE;
  logic                    ALUSrcE;
  logic                    BranchE;
  logic                    PCSE;
  logic                    NoWriteE;
  logic [2:0]              ALUControlE;
  logic [1:0]              FlagWE;
  logic [$clog2(NREG)-1:0] UopRdE;
  logic [OFFW-1:0]         UopOffE;
  logic                    UopE;

  modport master (
    output InstrD, ValidD, StallD, FlushD, FlushE,
    input  RegSrcD, ImmSrcD, BusyD, RegWE, MemWE, MemtoRegE, ALUSrcE, BranchE, PCSE,
    input  NoWriteE, ALUControlE, FlagWE, UopRdE, UopOffE, UopE
  );

  modport slave (
    input  InstrD, ValidD, StallD, FlushD, FlushE,
    output RegSrcD, ImmSrcD, BusyD, RegWE, MemWE, MemtoRegE, ALUSrcE, BranchE, PCSE,
    output NoWriteE, ALUControlE, FlagWE, UopRdE, UopOffE, UopE
  );
endinterface

// File: rtl/reglist_pe.sv
// Priority encoder over a block-transfer register list: lowest set index plus valid flag.
module reglist_pe #(
  parameter int unsigned NREG = 16
) (
  input  logic [NREG-1:0]         i_list,
  output logic [$clog2(NREG)-1:0] o_idx,
  output logic                    o_valid
);

  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = NREG - 1; i >= 0; i--) begin
      if (i_list[i]) begin
        o_idx   = ($clog2(NREG))'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/decode_seq.sv
// Decode stage with E pipeline register and an optional LDM/STM micro-op sequencer,
// enabled by defining DECODE_BLOCKXFER_EN.
module decode_seq
  import decode_pkg::*;
#(
  parameter int unsigned NREG = 16,
  parameter int unsigned OFFW = $clog2(NREG) + 2
) (
  input logic        clk,
  input logic        reset,
  decode_seq_if.slave bus
);

  localparam int unsigned RdW = $clog2(NREG);

  logic [1:0]     w_op;
  logic [5:0]     w_funct;
  logic [3:0]     w_rd;
  ectl_t          w_dec;
  logic [1:0]     w_dec_regsrc;
  logic [1:0]     w_dec_immsrc;
  logic           w_aluop;
  logic           w_arith;
  ectl_t          w_ectl;
  logic           w_uop;
  logic           w_uop_pcs;
  logic           w_busy;
  logic           w_unused_instr;
  ectl_t          r_e;

  assign w_op    = bus.InstrD[27:26];
  assign w_funct = bus.InstrD[25:20];
  assign w_rd    = bus.InstrD[15:12];
  assign w_unused_instr = ^{bus.InstrD[31:28], bus.InstrD[19:16], bus.InstrD[11:0]};

  always_comb begin
    w_dec        = '0;
    w_dec.alu    = AluAdd;
    w_dec_regsrc = 2'b00;
    w_dec_immsrc = 2'b00;
    w_aluop      = 1'b0;
    w_arith      = 1'b0;
    case (w_op)
      OpDp: begin
        w_dec.regw   = 1'b1;
        w_dec.alusrc = w_funct[5];
        w_aluop      = 1'b1;
      end
      OpMem: begin
        w_dec.alusrc = 1'b1;
        w_dec_immsrc = 2'b01;
        if (w_funct[0]) begin
          w_dec.regw     = 1'b1;
          w_dec.memtoreg = 1'b1;
        end else begin
          w_dec.memw   = 1'b1;
          w_dec_regsrc = 2'b10;
        end
      end
      OpBr: begin
        if (w_funct[5]) begin
          w_dec.branch = 1'b1;
          w_dec.alusrc = 1'b1;
          w_dec_immsrc = 2'b10;
          w_dec_regsrc = 2'b01;
        end
      end
      default: ;
    endcase
    if (w_aluop) begin
      case (w_funct[4:1])
        4'b0100: begin w_dec.alu = AluAdd; w_arith = 1'b1; end
        4'b0010: begin w_dec.alu = AluSub; w_arith = 1'b1; end
        4'b0000: w_dec.alu = AluAnd;
        4'b1100: w_dec.alu = AluOrr;
        4'b0001: w_dec.alu = AluEor;
        4'b1010: begin w_dec.alu = AluSub; w_arith = 1'b1; w_dec.nowrite = 1'b1; end
        4'b1011: begin w_dec.alu = AluAdd; w_arith = 1'b1; w_dec.nowrite = 1'b1; end
        4'b1000: begin w_dec.alu = AluAnd; w_dec.nowrite = 1'b1; end
        4'b1001: begin w_dec.alu = AluEor; w_dec.nowrite = 1'b1; end
        default: ;
      endcase
      w_dec.flagw = {w_funct[0], w_funct[0] & w_arith};
      if (w_dec.nowrite) w_dec.regw = 1'b0;
    end
    w_dec.pcs = ((w_rd == 4'd15) && w_dec.regw) || w_dec.branch;
  end

`ifdef DECODE_BLOCKXFER_EN
  state_e          r_state;
  logic [NREG-1:0] r_rem;
  logic [RdW-1:0]  r_k;
  logic            r_uop;
  logic [RdW-1:0]  r_rd;
  logic [OFFW-1:0] r_off;
  logic [NREG-1:0] w_list;
  logic [NREG-1:0] w_rest;
  logic [RdW-1:0]  w_idx;
  logic            w_any;
  logic            w_seq;
  logic [OFFW-1:0] w_off;

  // While sequencing, the held InstrD list is superseded by the remaining list.
  assign w_list = (r_state == StXfer) ? r_rem : bus.InstrD[NREG-1:0];

  reglist_pe #(
    .NREG (NREG)
  ) u_pe (
    .i_list  (w_list),
    .o_idx   (w_idx),
    .o_valid (w_any)
  );

  assign w_rest    = w_list & ~(NREG'(1) << w_idx);
  assign w_seq     = (r_state == StXfer) ||
                     (bus.ValidD && (w_op == OpBr) && !w_funct[5]);
  assign w_uop     = w_seq && w_any;
  assign w_busy    = w_uop && (w_rest != '0);
  assign w_off     = OFFW'({r_k, 2'b00});
  assign w_uop_pcs = (32'(w_idx) == 32'd15);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_rem   <= '0;
      r_k     <= '0;
    end else if (bus.FlushD) begin
      r_state <= StIdle;
      r_rem   <= '0;
      r_k     <= '0;
    end else if (!bus.StallD) begin
      if (w_busy) begin
        r_state <= StXfer;
        r_rem   <= w_rest;
        r_k     <= r_k + RdW'(1);
      end else begin
        r_state <= StIdle;
        r_rem   <= '0;
        r_k     <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_uop <= 1'b0;
      r_rd  <= '0;
      r_off <= '0;
    end else if (bus.FlushE) begin
      r_uop <= 1'b0;
      r_rd  <= '0;
      r_off <= '0;
    end else if (!bus.StallD) begin
      r_uop <= w_uop;
      r_rd  <= w_uop ? w_idx : '0;
      r_off <= w_uop ? w_off : '0;
    end
  end

  assign bus.UopE    = r_uop;
  assign bus.UopRdE  = r_rd;
  assign bus.UopOffE = r_off;
`else
  assign w_uop       = 1'b0;
  assign w_uop_pcs   = 1'b0;
  assign w_busy      = 1'b0;
  assign bus.UopE    = 1'b0;
  assign bus.UopRdE  = '0;
  assign bus.UopOffE = '0;
`endif

  always_comb begin
    w_ectl      = bus.ValidD ? w_dec : '0;
    bus.RegSrcD = w_dec_regsrc;
    bus.ImmSrcD = w_dec_immsrc;
    if (w_uop) begin
      w_ectl          = '0;
      w_ectl.alu      = AluAdd;
      w_ectl.alusrc   = 1'b1;
      w_ectl.regw     = w_funct[0];
      w_ectl.memtoreg = w_funct[0];
      w_ectl.memw     = !w_funct[0];
      w_ectl.pcs      = w_funct[0] && w_uop_pcs;
      bus.RegSrcD     = w_funct[0] ? 2'b00 : 2'b10;
      bus.ImmSrcD     = 2'b01;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_e <= '0;
    end else if (bus.FlushE) begin
      r_e <= '0;
    end else if (!bus.StallD) begin
      r_e <= w_ectl;
    end
  end

  // Gated by reset so Fetch is never told to hold while the core is in reset.
  assign bus.BusyD       = reset & w_busy;
  assign bus.RegWE       = r_e.regw;
  assign bus.MemWE       = r_e.memw;
  assign bus.MemtoRegE   = r_e.memtoreg;
  assign bus.ALUSrcE     = r_e.alusrc;
  assign bus.BranchE     = r_e.branch;
  assign bus.PCSE        = r_e.pcs;
  assign bus.NoWriteE    = r_e.nowrite;
  assign bus.ALUControlE = r_e.alu;
  assign bus.FlagWE      = r_e.flagw;

endmodule

// File: tb/tb_decode_seq.sv
// Scoreboard bench for decode_seq; block-transfer cases run when DECODE_BLOCKXFER_EN is set.
module tb_decode_seq;

  typedef struct packed {
    logic       regwe;
    logic       memwe;
    logic       memtoreg;
    logic       alusrc;
    logic       branch;
    logic       pcs;
    logic       nowrite;
    logic [2:0] alu;
    logic [1:0] flagw;
    logic       uop;
    logic [3:0] uoprd;
    logic [5:0] uopoff;
  } e_t;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;
  e_t   sb_q[$];
  string nm_q[$];
  e_t   bub;

  decode_seq_if #(.NREG(16)) bus ();

  decode_seq u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic e_t dut_e();
    e_t e;
    e.regwe    = bus.RegWE;
    e.memwe    = bus.MemWE;
    e.memtoreg = bus.MemtoRegE;
    e.alusrc   = bus.ALUSrcE;
    e.branch   = bus.BranchE;
    e.pcs      = bus.PCSE;
    e.nowrite  = bus.NoWriteE;
    e.alu      = bus.ALUControlE;
    e.flagw    = bus.FlagWE;
    e.uop      = bus.UopE;
    e.uoprd    = bus.UopRdE;
    e.uopoff   = bus.UopOffE;
    return e;
  endfunction

  function automatic e_t dp(input logic [2:0] alu, input logic [1:0] fw, input logic nw,
                            input logic src, input logic pcs);
    e_t e = '0;
    e.regwe = !nw; e.nowrite = nw; e.alu = alu; e.flagw = fw; e.alusrc = src; e.pcs = pcs;
    return e;
  endfunction

  function automatic e_t mem(input logic ld, input logic br);
    e_t e = '0;
    e.alusrc = 1'b1;
    if (br) begin e.branch = 1'b1; e.pcs = 1'b1; end
    else if (ld) begin e.regwe = 1'b1; e.memtoreg = 1'b1; end
    else e.memwe = 1'b1;
    return e;
  endfunction

  function automatic e_t uop(input logic ld, input logic [3:0] rd, input logic [5:0] off,
                             input logic pcs);
    e_t e = mem(ld, 1'b0);
    e.uop = 1'b1; e.uoprd = rd; e.uopoff = off; e.pcs = pcs;
    return e;
  endfunction

  task automatic chk_e(input string nm, input e_t got, input e_t exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic chk_b(input string nm, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", nm, got, exp);
    end
  endtask

  task automatic cyc(input string nm, input logic [31:0] ins, input logic v, input logic st,
                     input logic fd, input logic fe, input e_t exp, input int busy);
    @(negedge clk);
    bus.InstrD = ins; bus.ValidD = v; bus.StallD = st; bus.FlushD = fd; bus.FlushE = fe;
    if (!st || fe) begin
      sb_q.push_back(exp);
      nm_q.push_back(nm);
    end
    #1;
    if (busy >= 0) chk_b({nm, "_busy"}, bus.BusyD, busy[0]);
  endtask

  task automatic run(input string nm, input logic [31:0] ins, input e_t exp, input int busy);
    cyc(nm, ins, 1'b1, 1'b0, 1'b0, 1'b0, exp, busy);
  endtask

  // Monitor: every loading edge pops one expectation, every held edge must keep the last one.
  initial begin : monitor
    e_t    exp;
    e_t    last;
    string nm;
    logic  ld;
    last = '0;
    forever begin
      @(posedge clk);
      ld = reset && (!bus.StallD || bus.FlushE);
      #1;
      if (!reset) begin
        last = '0;
      end else if (ld) begin
        if (sb_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL sb_underflow: got an E load, want none pending");
        end else begin
          exp = sb_q.pop_front();
          nm  = nm_q.pop_front();
          chk_e(nm, dut_e(), exp);
          last = exp;
        end
      end else begin
        chk_e("stall_hold", dut_e(), last);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    n_chk = 0; n_fail = 0; bub = '0;
    reset = 1'b0;
    bus.InstrD = 32'hE8900092; bus.ValidD = 1'b1;
    bus.StallD = 1'b1; bus.FlushD = 1'b0; bus.FlushE = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_e("reset_e", dut_e(), '0);
    chk_b("reset_busy", bus.BusyD, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    run("adds",  32'hE0921003, dp(3'b000, 2'b11, 1'b0, 1'b0, 1'b0), 0);
    run("cmp",   32'hE3500005, dp(3'b001, 2'b11, 1'b1, 1'b1, 1'b0), 0);
    run("sub",   32'hE0454006, dp(3'b001, 2'b00, 1'b0, 1'b0, 1'b0), 0);
    run("ands",  32'hE21100FF, dp(3'b010, 2'b10, 1'b0, 1'b1, 1'b0), 0);
    run("orr",   32'hE1822003, dp(3'b011, 2'b00, 1'b0, 1'b0, 1'b0), 0);
    run("eors",  32'hE0387009, dp(3'b110, 2'b10, 1'b0, 1'b0, 1'b0), 0);
    run("tst",   32'hE3110001, dp(3'b010, 2'b10, 1'b1, 1'b1, 1'b0), 0);
    run("add_pc", 32'hE080F001, dp(3'b000, 2'b00, 1'b0, 1'b0, 1'b1), 0);
    run("ldr",   32'hE5943008, mem(1'b1, 1'b0), 0);
    run("str",   32'hE5843000, mem(1'b0, 1'b0), 0);
    run("b",     32'hEA000010, mem(1'b0, 1'b1), 0);
    run("op11",  32'hEC000000, bub, 0);
    cyc("invalid", 32'hE0921003, 1'b0, 1'b0, 1'b0, 1'b0, bub, 0);
    cyc("flushe", 32'hE0921003, 1'b1, 1'b0, 1'b0, 1'b1, bub, 0);
    run("sub2",  32'hE0454006, dp(3'b001, 2'b00, 1'b0, 1'b0, 1'b0), 0);
    cyc("stall", 32'hE0921003, 1'b1, 1'b1, 1'b0, 1'b0, bub, 0);
    cyc("stall_flushe", 32'hE0921003, 1'b1, 1'b1, 1'b0, 1'b1, bub, 0);
    run("adds2", 32'hE0921003, dp(3'b000, 2'b11, 1'b0, 1'b0, 1'b0), 0);

`ifdef DECODE_BLOCKXFER_EN
    run("ldm3_u0", 32'hE8900092, uop(1'b1, 4'd1, 6'd0, 1'b0), 1);
    run("ldm3_u1", 32'hE8900092, uop(1'b1, 4'd4, 6'd4, 1'b0), 1);
    run("ldm3_u2", 32'hE8900092, uop(1'b1, 4'd7, 6'd8, 1'b0), 0);
    run("after_ldm", 32'hE0921003, dp(3'b000, 2'b11, 1'b0, 1'b0, 1'b0), 0);

    run("stm_u0", 32'hE8800003, uop(1'b0, 4'd0, 6'd0, 1'b0), 1);
    cyc("stm_st1", 32'hE8800003, 1'b1, 1'b1, 1'b0, 1'b0, bub, 0);
    cyc("stm_st2", 32'hE8800003, 1'b1, 1'b1, 1'b0, 1'b0, bub, 0);
    run("stm_u1", 32'hE8800003, uop(1'b0, 4'd1, 6'd4, 1'b0), 0);

    run("ldm1", 32'hE8900010, uop(1'b1, 4'd4, 6'd0, 1'b0), 0);
    run("ldm0", 32'hE8900000, bub, 0);
    run("ldmpc_u0", 32'hE8908001, uop(1'b1, 4'd0, 6'd0, 1'b0), 1);
    run("ldmpc_u1", 32'hE8908001, uop(1'b1, 4'd15, 6'd4, 1'b1), 0);

    run("ldm8_u0", 32'hE89000FF, uop(1'b1, 4'd0, 6'd0, 1'b0), 1);
    run("ldm8_u1", 32'hE89000FF, uop(1'b1, 4'd1, 6'd4, 1'b0), 1);
    run("ldm8_u2", 32'hE89000FF, uop(1'b1, 4'd2, 6'd8, 1'b0), 1);
    cyc("ldm8_flushd", 32'hE89000FF, 1'b1, 1'b0, 1'b1, 1'b0, uop(1'b1, 4'd3, 6'd12, 1'b0), -1);
    cyc("post_flushd", 32'hE89000FF, 1'b0, 1'b0, 1'b0, 1'b0, bub, 0);

    run("fde_u0", 32'hE8900092, uop(1'b1, 4'd1, 6'd0, 1'b0), 1);
    cyc("fde_flush", 32'hE8900092, 1'b1, 1'b0, 1'b1, 1'b1, bub, -1);
    cyc("post_fde", 32'hE8900092, 1'b0, 1'b0, 1'b0, 1'b0, bub, 0);

    run("rst8_u0", 32'hE89000FF, uop(1'b1, 4'd0, 6'd0, 1'b0), 1);
    run("rst8_u1", 32'hE89000FF, uop(1'b1, 4'd1, 6'd4, 1'b0), 1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk_e("rst_async_e", dut_e(), '0);
    chk_b("rst_async_busy", bus.BusyD, 1'b0);
    @(negedge clk);
    bus.StallD = 1'b1; bus.ValidD = 1'b0;
    reset = 1'b1;
    run("post_rst", 32'hE8900092, uop(1'b1, 4'd1, 6'd0, 1'b0), 1);
    run("post_rst_u1", 32'hE8900092, uop(1'b1, 4'd4, 6'd4, 1'b0), 1);
    run("post_rst_u2", 32'hE8900092, uop(1'b1, 4'd7, 6'd8, 1'b0), 0);
`else
    run("blk_off", 32'hE8900092, bub, 0);
    run("blk_off_stm", 32'hE8800003, bub, 0);
`endif

    @(negedge clk);
    bus.StallD = 1'b1; bus.ValidD = 1'b0; bus.FlushD = 1'b0; bus.FlushE = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending, want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
